// File: rtl/tick_period_monitor_pkg.sv
// -----------------------------------------------------------------------------
// tick_period_monitor_pkg
// Shared definitions for the tick period monitor.
//   state_e     : measurement state (IDLE = waiting for an arming tick,
//                 RUN = measuring the distance to the next tick)
//   TICK_CNT_W  : width of the free-running tick counter output
// -----------------------------------------------------------------------------
package tick_period_monitor_pkg;

  localparam int TICK_CNT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage : tick_period_monitor_pkg

// File: rtl/tick_period_monitor.sv
// -----------------------------------------------------------------------------
// tick_period_monitor
// Consumer-side checker for single-cycle clock-enable tick streams. It measures
// the clk_i-cycle distance between consecutive ticks and reports each period.
// A period outside EXPECTED +/- TOL sets a sticky error. If ticks stop for
// TIMEOUT cycles while measuring, a sticky timeout is raised and the monitor
// disarms.
//
// Ports:
//   clk_i          : system clock
//   resetn_i       : asynchronous active-low reset
//   tick_i         : tick pulse under test, synchronous to clk_i
//   clear_i        : synchronous clear of measurement state and sticky flags
//   period_o       : last measured period (holds between strobes)
//   period_valid_o : one-cycle strobe, period_o updated this cycle
//   err_o          : sticky, some period fell outside tolerance
//   tick_count_o   : ticks seen since reset/clear, wraps at 16'hFFFF -> 0
//   timeout_o      : sticky, TIMEOUT cycles passed in RUN without a tick
// -----------------------------------------------------------------------------
module tick_period_monitor
  import tick_period_monitor_pkg::*;
#(
  parameter int unsigned          CNT_W    = 8,
  parameter logic [CNT_W-1:0]     EXPECTED = 8'd7,
  parameter logic [CNT_W-1:0]     TOL      = 8'd0,
  parameter logic [CNT_W-1:0]     TIMEOUT  = 8'd255
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  tick_i,
  input  logic                  clear_i,
  output logic [CNT_W-1:0]      period_o,
  output logic                  period_valid_o,
  output logic                  err_o,
  output logic                  timeout_o,
  output logic [TICK_CNT_W-1:0] tick_count_o
);

  // Tolerance window evaluated one bit wider so EXPECTED+TOL cannot wrap;
  // the lower bound saturates at zero when TOL exceeds EXPECTED.
  localparam logic [CNT_W:0] LIMIT_LO = (EXPECTED > TOL) ?
                                        ({1'b0, EXPECTED} - {1'b0, TOL}) : '0;
  localparam logic [CNT_W:0] LIMIT_HI = {1'b0, EXPECTED} + {1'b0, TOL};

  localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TICK_CNT_W-1:0] TICK_ONE = {{(TICK_CNT_W-1){1'b0}}, 1'b1};

  state_e                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_period;
  logic                  r_period_valid;
  logic                  r_err;
  logic                  r_timeout;
  logic [TICK_CNT_W-1:0] r_tick_count;

  logic [CNT_W:0]        w_cnt_ext;
  logic                  w_out_of_range;

  // r_cnt equals the distance to the previous tick at the edge a new tick is
  // sampled, so it is compared directly as the candidate period.
  assign w_cnt_ext      = {1'b0, r_cnt};
  assign w_out_of_range = (w_cnt_ext < LIMIT_LO) || (w_cnt_ext > LIMIT_HI);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_err          <= 1'b0;
      r_timeout      <= 1'b0;
      r_tick_count   <= '0;
    end else begin
      r_period_valid <= 1'b0;
      if (clear_i) begin
        // Clear wins over a coincident tick: the tick is neither counted
        // nor used to arm.
        r_state      <= ST_IDLE;
        r_cnt        <= '0;
        r_period     <= '0;
        r_err        <= 1'b0;
        r_timeout    <= 1'b0;
        r_tick_count <= '0;
      end else if (tick_i) begin
        r_tick_count <= r_tick_count + TICK_ONE;
        r_cnt        <= CNT_ONE;
        if (r_state == ST_RUN) begin
          r_period       <= r_cnt;
          r_period_valid <= 1'b1;
          if (w_out_of_range) begin
            r_err <= 1'b1;
          end
        end else begin
          // First tick after idle only arms the measurement.
          r_state <= ST_RUN;
        end
      end else if (r_state == ST_RUN) begin
        if (r_cnt == TIMEOUT) begin
          r_timeout <= 1'b1;
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end
    end
  end

  assign period_o       = r_period;
  assign period_valid_o = r_period_valid;
  assign err_o          = r_err;
  assign timeout_o      = r_timeout;
  assign tick_count_o   = r_tick_count;

endmodule : tick_period_monitor

// File: tb/tb_tick_period_monitor.sv
// -----------------------------------------------------------------------------
// tb_tick_period_monitor
// Four monitors with different EXPECTED/TOL settings share one tick stream.
// A behavioural model tracks, per monitor, the edge index of the last arming
// tick; periods are edge-index differences and timeout fires when that
// difference reaches TIMEOUT without a tick. All outputs are compared after
// every clock edge.
//   inst 0: EXPECTED=7 TOL=0   inst 1: EXPECTED=7 TOL=1
//   inst 2: EXPECTED=7 TOL=2   inst 3: EXPECTED=1 TOL=0 (clean wrap run)
// -----------------------------------------------------------------------------
module tb_tick_period_monitor;

  localparam int N_INST  = 4;
  localparam int TIMEOUT = 255;

  logic clk;
  logic resetn;
  logic tick;
  logic clear;

  logic [7:0]  period_w [N_INST];
  logic        valid_w  [N_INST];
  logic        err_w    [N_INST];
  logic        to_w     [N_INST];
  logic [15:0] count_w  [N_INST];

  generate
    for (genvar gi = 0; gi < N_INST; gi++) begin : g_dut
      tick_period_monitor #(
        .CNT_W    (8),
        .EXPECTED ((gi == 3) ? 8'd1 : 8'd7),
        .TOL      ((gi == 1) ? 8'd1 : ((gi == 2) ? 8'd2 : 8'd0)),
        .TIMEOUT  (8'd255)
      ) u_dut (
        .clk_i          (clk),
        .resetn_i       (resetn),
        .tick_i         (tick),
        .clear_i        (clear),
        .period_o       (period_w[gi]),
        .period_valid_o (valid_w[gi]),
        .err_o          (err_w[gi]),
        .timeout_o      (to_w[gi]),
        .tick_count_o   (count_w[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_exp [N_INST] = '{7, 7, 7, 1};
  int m_tol [N_INST] = '{0, 1, 2, 0};
  bit m_armed  [N_INST];
  int m_last   [N_INST];
  int m_period [N_INST];
  bit m_valid  [N_INST];
  bit m_err    [N_INST];
  bit m_to     [N_INST];
  int m_count  [N_INST];
  int n_edge;

  int n_checks;
  int n_errors;

  task automatic model_reset();
    for (int i = 0; i < N_INST; i++) begin
      m_armed[i]  = 1'b0;
      m_last[i]   = 0;
      m_period[i] = 0;
      m_valid[i]  = 1'b0;
      m_err[i]    = 1'b0;
      m_to[i]     = 1'b0;
      m_count[i]  = 0;
    end
  endtask

  task automatic model_edge(input bit t, input bit c);
    int p;
    int lo;
    n_edge++;
    for (int i = 0; i < N_INST; i++) begin
      m_valid[i] = 1'b0;
      if (c) begin
        m_armed[i]  = 1'b0;
        m_period[i] = 0;
        m_err[i]    = 1'b0;
        m_to[i]     = 1'b0;
        m_count[i]  = 0;
      end else if (t) begin
        m_count[i] = (m_count[i] + 1) % 65536;
        if (m_armed[i]) begin
          p           = n_edge - m_last[i];
          m_period[i] = p;
          m_valid[i]  = 1'b1;
          lo          = (m_exp[i] > m_tol[i]) ? m_exp[i] - m_tol[i] : 0;
          if (p < lo || p > m_exp[i] + m_tol[i]) m_err[i] = 1'b1;
        end
        m_armed[i] = 1'b1;
        m_last[i]  = n_edge;
      end else if (m_armed[i] && (n_edge - m_last[i] == TIMEOUT)) begin
        m_to[i]    = 1'b1;
        m_armed[i] = 1'b0;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N_INST; i++) begin
      check_val($sformatf("%s.period[%0d]", tag, i), int'(period_w[i]), m_period[i]);
      check_val($sformatf("%s.valid[%0d]", tag, i), int'(valid_w[i]), int'(m_valid[i]));
      check_val($sformatf("%s.err[%0d]", tag, i), int'(err_w[i]), int'(m_err[i]));
      check_val($sformatf("%s.timeout[%0d]", tag, i), int'(to_w[i]), int'(m_to[i]));
      check_val($sformatf("%s.count[%0d]", tag, i), int'(count_w[i]), m_count[i]);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic step(input bit t, input bit c, input string tag);
    @(negedge clk);
    tick  = t;
    clear = c;
    @(posedge clk);
    model_edge(t, c);
    #1;
    check_all(tag);
  endtask

  // One tick followed by gap-1 idle cycles, so the next tick closes a
  // period of exactly gap.
  task automatic tick_gap(input int gap, input string tag);
    step(1'b1, 1'b0, tag);
    for (int k = 1; k < gap; k++) step(1'b0, 1'b0, tag);
    $display("%s: tick gap=%0d period=%0d err=%0b timeout=%0b count=%0d",
             tag, gap, period_w[0], err_w[0], to_w[0], count_w[0]);
  endtask

  task automatic do_clear(input string tag);
    step(1'b0, 1'b1, tag);
    $display("%s: clear", tag);
  endtask

  initial begin
    int r;
    n_checks = 0;
    n_errors = 0;
    n_edge   = 0;
    resetn   = 1'b0;
    tick     = 1'b0;
    clear    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    resetn = 1'b1;

    // 1: nominal period 7, ten ticks
    for (int i = 0; i < 10; i++) tick_gap(7, "t1");
    check_val("t1_count", int'(count_w[0]), 10);
    check_val("t1_err", int'(err_w[0]), 0);

    // 2: tolerance windows
    do_clear("t2");
    tick_gap(7, "t2"); tick_gap(8, "t2"); tick_gap(6, "t2");
    tick_gap(9, "t2"); tick_gap(5, "t2"); tick_gap(9, "t2");
    step(1'b1, 1'b0, "t2");
    check_val("t2_err_tol1", int'(err_w[1]), 1);
    check_val("t2_err_tol2", int'(err_w[2]), 0);

    // 3: timeout, then re-arm
    do_clear("t3");
    tick_gap(300, "t3");
    check_val("t3_timeout", int'(to_w[0]), 1);
    tick_gap(7, "t3");
    step(1'b1, 1'b0, "t3");
    check_val("t3_period", int'(period_w[0]), 7);

    // 4: back-to-back ticks, then clear with a coincident tick
    do_clear("t4");
    step(1'b1, 1'b0, "t4");
    step(1'b1, 1'b0, "t4");
    check_val("t4_period", int'(period_w[0]), 1);
    check_val("t4_err", int'(err_w[0]), 1);
    step(1'b1, 1'b1, "t4_clr_tick");
    check_val("t4_count", int'(count_w[0]), 0);
    step(1'b1, 1'b0, "t4_arm");
    check_val("t4_arm_valid", int'(valid_w[0]), 0);
    step(1'b0, 1'b0, "t4");
    $display("t4: back-to-back and clear+tick done");

    // 5: asynchronous reset mid-measurement (cnt=4 in RUN)
    do_clear("t5");
    step(1'b1, 1'b0, "t5");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, "t5");
    #3;
    resetn = 1'b0;
    model_reset();
    #1;
    check_all("t5_arst");
    @(posedge clk);
    #1;
    check_all("t5_arst_hold");
    @(negedge clk);
    resetn = 1'b1;
    $display("t5: async reset applied and released");
    tick_gap(7, "t5");
    step(1'b1, 1'b0, "t5");
    check_val("t5_period", int'(period_w[0]), 7);

    // random gaps, occasional long gaps and clears
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        step(1'($urandom_range(0, 1)), 1'b1, "rnd_clr");
        $display("rnd: clear");
      end else if (r < 10) begin
        tick_gap(int'($urandom_range(250, 260)), "rnd");
      end else begin
        tick_gap(int'($urandom_range(1, 12)), "rnd");
      end
    end

    // 6: tick counter wrap (inst 3 expects period 1)
    do_clear("t6");
    for (int i = 0; i < 65537; i++) step(1'b1, 1'b0, "t6");
    $display("t6: 65537 ticks, count=%0d", count_w[3]);
    check_val("t6_wrap", int'(count_w[3]), 1);
    check_val("t6_err", int'(err_w[3]), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_tick_period_monitor
